// File: rtl/plot_framebuffer.sv
// Plot framebuffer: buffers plot writes in a FIFO and commits them one per
// cycle into a single-port colour RAM. Also serves pixel readback (two-cycle
// latency) and full-screen clears. The RAM port is shared in priority order:
// clear > readback > FIFO drain.
module plot_framebuffer #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = 3,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        plot,
  input  logic [X_BITS-1:0]           x,
  input  logic [Y_BITS-1:0]           y,
  input  logic [COLOUR_BITS-1:0]      colour,
  output logic                        ready,
  input  logic                        clear_req,
  input  logic [COLOUR_BITS-1:0]      clear_colour,
  output logic                        clear_busy,
  input  logic                        rd_req,
  input  logic [X_BITS-1:0]           rd_x,
  input  logic [Y_BITS-1:0]           rd_y,
  output logic                        rd_valid,
  output logic [COLOUR_BITS-1:0]      rd_colour,
  output logic                        oob_drop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  typedef enum logic {S_RUN, S_CLEAR} state_t;

  state_t                   r_state;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         r_level;
  logic [ADDR_W-1:0]        r_clr_cnt;
  logic [COLOUR_BITS-1:0]   r_clr_colour;
  logic                     r_clear_busy;
  logic                     r_oob_drop;
  logic                     r_rd_vld_p0;
  logic                     r_rd_oob_p0;
  logic [COLOUR_BITS-1:0]   r_ram_q_p0;
  logic                     r_rd_valid_p1;
  logic [COLOUR_BITS-1:0]   r_rd_colour_p1;

  logic [X_BITS-1:0]        r_fifo_x [FIFO_DEPTH];
  logic [Y_BITS-1:0]        r_fifo_y [FIFO_DEPTH];
  logic [COLOUR_BITS-1:0]   r_fifo_c [FIFO_DEPTH];
  logic [COLOUR_BITS-1:0]   r_mem    [NPIX];

  logic                     w_full;
  logic                     w_in_range;
  logic                     w_rd_in_range;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_rd_issue;
  logic                     w_ram_we;
  logic [ADDR_W-1:0]        w_ram_addr;
  logic [COLOUR_BITS-1:0]   w_ram_wd;

  // Linear pixel address, row-major.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_BITS-1:0] px,
                                                 input logic [Y_BITS-1:0] py);
    return ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
  endfunction

  assign w_full        = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_in_range    = ({1'b0, x} < (X_BITS+1)'(WIDTH)) && ({1'b0, y} < (Y_BITS+1)'(HEIGHT));
  assign w_rd_in_range = ({1'b0, rd_x} < (X_BITS+1)'(WIDTH)) && ({1'b0, rd_y} < (Y_BITS+1)'(HEIGHT));
  assign ready         = (r_state == S_RUN) && !w_full && !reset;
  assign w_accept      = plot && ready;
  // A clear request flushes the FIFO, so a plot accepted in that cycle is lost too.
  assign w_push        = w_accept && w_in_range && !clear_req;
  assign w_rd_issue    = (r_state == S_RUN) && rd_req;
  assign w_pop         = (r_state == S_RUN) && !rd_req && (r_level != '0);

  assign clear_busy = r_clear_busy;
  assign oob_drop   = r_oob_drop;
  assign rd_valid   = r_rd_valid_p1;
  assign rd_colour  = r_rd_colour_p1;
  assign fifo_level = r_level;

  // RAM port arbitration: clear sweep, then readback, then FIFO drain.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = '0;
    w_ram_wd   = '0;
    if (r_state == S_CLEAR) begin
      w_ram_we   = !reset;
      w_ram_addr = r_clr_cnt;
      w_ram_wd   = r_clr_colour;
    end else if (rd_req) begin
      w_ram_addr = w_rd_in_range ? pix_addr(rd_x, rd_y) : '0;
    end else if (w_pop) begin
      w_ram_we   = !reset;
      w_ram_addr = pix_addr(r_fifo_x[r_rd_ptr], r_fifo_y[r_rd_ptr]);
      w_ram_wd   = r_fifo_c[r_rd_ptr];
    end
  end

  // Single-port framebuffer RAM, read-first; data path, never reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wd;
    r_ram_q_p0 <= r_mem[w_ram_addr];
  end

  // FIFO payload storage, readback range flag and sampled clear colour.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_x[r_wr_ptr] <= x;
      r_fifo_y[r_wr_ptr] <= y;
      r_fifo_c[r_wr_ptr] <= colour;
    end
    r_rd_oob_p0 <= !w_rd_in_range;
    if ((r_state == S_RUN) && clear_req) r_clr_colour <= clear_colour;
  end

  // Control: RUN/CLEAR FSM, FIFO pointers/level, readback pipeline and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_RUN;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_clr_cnt      <= '0;
      r_clear_busy   <= 1'b0;
      r_oob_drop     <= 1'b0;
      r_rd_vld_p0    <= 1'b0;
      r_rd_valid_p1  <= 1'b0;
      r_rd_colour_p1 <= '0;
    end else begin
      r_oob_drop    <= w_accept && !w_in_range;
      r_rd_vld_p0   <= w_rd_issue;
      // ---- readback stage p0 -> p1 ----
      r_rd_valid_p1 <= r_rd_vld_p0;
      if (r_rd_vld_p0) r_rd_colour_p1 <= r_rd_oob_p0 ? '0 : r_ram_q_p0;
      case (r_state)
        S_RUN: begin
          if (clear_req) begin
            r_state      <= S_CLEAR;
            r_clear_busy <= 1'b1;
            r_clr_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
          end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
              2'b10:   r_level <= r_level + LVL_W'(1);
              2'b01:   r_level <= r_level - LVL_W'(1);
              default: r_level <= r_level;
            endcase
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == ADDR_W'(NPIX - 1)) begin
            r_state      <= S_RUN;
            r_clear_busy <= 1'b0;
            r_clr_cnt    <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
